// File: rtl/mdu_pkg.sv
// Shared types and constants for the execute-stage multiply/divide unit.
package mdu_pkg;
  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MADD  = 3'd4,
    MD_MADDU = 3'd5,
    MD_MSUB  = 3'd6,
    MD_MSUBU = 3'd7
  } mdop_e;

  localparam int MDU_MULT_LAT_DEF = 5;
  localparam int MDU_DIV_LAT_DEF  = 10;

  localparam logic HL_LO = 1'b0;
  localparam logic HL_HI = 1'b1;
endpackage

// File: rtl/mdu_arith.sv
// Combinational datapath for the MDU: products, quotient/remainder and the
// optional MADD/MSUB accumulate (enabled by MDU_MADD_EN).
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rt,
  input  logic [2:0]  i_mdop,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  output logic [63:0] o_result
);
  mdop_e       w_op;
  logic        w_sgn;
  logic [63:0] w_rs64, w_rt64, w_prod;
  logic        w_rs_neg, w_rt_neg;
  logic [31:0] w_rs_mag, w_rt_mag, w_div, w_q_mag, w_r_mag, w_quo, w_rem;

  assign w_op  = mdop_e'(i_mdop);
  assign w_sgn = ~i_mdop[0];

  // Low 64 bits of the product of sign/zero-extended operands is exact for both signednesses.
  assign w_rs64 = {{32{w_sgn & i_rs[31]}}, i_rs};
  assign w_rt64 = {{32{w_sgn & i_rt[31]}}, i_rt};
  assign w_prod = w_rs64 * w_rt64;

  // Signed divide on magnitudes: truncates toward zero, remainder follows the dividend.
  assign w_rs_neg = w_sgn & i_rs[31];
  assign w_rt_neg = w_sgn & i_rt[31];
  assign w_rs_mag = w_rs_neg ? -i_rs : i_rs;
  assign w_rt_mag = w_rt_neg ? -i_rt : i_rt;
  assign w_div    = (i_rt == '0) ? 32'd1 : w_rt_mag;
  assign w_q_mag  = w_rs_mag / w_div;
  assign w_r_mag  = w_rs_mag % w_div;
  assign w_quo    = (w_rs_neg ^ w_rt_neg) ? -w_q_mag : w_q_mag;
  assign w_rem    = w_rs_neg ? -w_r_mag : w_r_mag;

  always_comb begin
    o_result = {i_hi, i_lo};
    case (w_op)
      MD_MULT, MD_MULTU: o_result = w_prod;
      MD_DIV, MD_DIVU:   if (i_rt != '0) o_result = {w_rem, w_quo};
`ifdef MDU_MADD_EN
      MD_MADD, MD_MADDU: o_result = {i_hi, i_lo} + w_prod;
      MD_MSUB, MD_MSUBU: o_result = {i_hi, i_lo} - w_prod;
`endif
      default: ;
    endcase
  end
endmodule

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: fixed-latency busy counter, pending
// result, HI/LO commit. MADD/MSUB ops exist only with MDU_MADD_EN defined.
module e_mdu
  import mdu_pkg::*;
#(
  parameter int MULT_LAT = MDU_MULT_LAT_DEF,
  parameter int DIV_LAT  = MDU_DIV_LAT_DEF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_mdstart,
  input  logic [2:0]  i_mdop,
  input  logic        i_hlwrite,
  input  logic        i_hlsel,
  input  logic        i_hlread,
  input  logic [31:0] i_rs_val,
  input  logic [31:0] i_rt_val,
  input  logic        i_req,
  output logic        o_busy,
  output logic [31:0] o_hl_rdata
);
  localparam int CW = $clog2(DIV_LAT + 1);

  logic [CW-1:0] r_cnt;
  logic [31:0]   r_hi, r_lo, r_pend_hi, r_pend_lo;
  logic [63:0]   w_result;
  logic          w_busy, w_op_ok, w_start, w_hlwr;
  logic [CW-1:0] w_lat;

  mdu_arith u_arith (
    .i_rs     (i_rs_val),
    .i_rt     (i_rt_val),
    .i_mdop   (i_mdop),
    .i_hi     (r_hi),
    .i_lo     (r_lo),
    .o_result (w_result)
  );

`ifdef MDU_MADD_EN
  assign w_op_ok = 1'b1;
`else
  assign w_op_ok = ~i_mdop[2];
`endif

  assign w_busy  = (r_cnt != '0);
  assign w_start = i_mdstart & ~i_req & ~w_busy & w_op_ok;
  assign w_hlwr  = i_hlwrite & ~i_req & ~w_busy;
  assign w_lat   = (i_mdop[2:1] == 2'b01) ? CW'(DIV_LAT) : CW'(MULT_LAT);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
    end else begin
      if (w_start) begin
        r_cnt                  <= w_lat;
        {r_pend_hi, r_pend_lo} <= w_result;
      end else if (w_busy) begin
        r_cnt <= r_cnt - 1'b1;
        // An in-flight op always commits, regardless of req.
        if (r_cnt == CW'(1)) begin
          r_hi <= r_pend_hi;
          r_lo <= r_pend_lo;
        end
      end
      if (w_hlwr) begin
        if (i_hlsel == HL_HI) r_hi <= i_rs_val;
        else                  r_lo <= i_rs_val;
      end
    end
  end

  assign o_busy     = w_busy;
  assign o_hl_rdata = i_hlread ? ((i_hlsel == HL_HI) ? r_hi : r_lo) : '0;
endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed scenarios plus randomized ops
// against an arithmetic reference model of HI/LO.
module tb_e_mdu;
  logic        clk = 0, rst_n = 0;
  logic        mdstart = 0, hlwrite = 0, hlsel = 0, hlread = 0, req = 0;
  logic [2:0]  mdop = 0;
  logic [31:0] rs_val = 0, rt_val = 0;
  logic        busy;
  logic [31:0] hl_rdata;

  int n_pass = 0, n_total = 0;
  logic [31:0] m_hi = 0, m_lo = 0;

  e_mdu dut (
    .i_clk(clk), .i_reset(rst_n), .i_mdstart(mdstart), .i_mdop(mdop),
    .i_hlwrite(hlwrite), .i_hlsel(hlsel), .i_hlread(hlread),
    .i_rs_val(rs_val), .i_rt_val(rt_val), .i_req(req),
    .o_busy(busy), .o_hl_rdata(hl_rdata)
  );

  always #5 clk = ~clk;

  function automatic bit op_active(input logic [2:0] op);
`ifdef MDU_MADD_EN
    return 1'b1;
`else
    return op < 3'd4;
`endif
  endfunction

  function automatic int op_lat(input logic [2:0] op);
    return (op == 3'd2 || op == 3'd3) ? 10 : 5;
  endfunction

  function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a, b,
                                         input logic [63:0] hl);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = int'(a);
    sb = int'(b);
    if (op[0]) p = {32'b0, a} * {32'b0, b};
    else       p = sa * sb;
    case (op)
      3'd0, 3'd1: return p;
      3'd2: begin
        if (b == 0) return hl;
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd3: return (b == 0) ? hl : {a % b, a / b};
      3'd4, 3'd5: return hl + p;
      default: return hl - p;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic sel, output logic [31:0] v);
    hlread = 1; hlsel = sel;
    #1;
    v = hl_rdata;
    hlread = 0; hlsel = 0;
  endtask

  task automatic rd_hl(output logic [63:0] v);
    logic [31:0] h, l;
    rd(1'b1, h);
    rd(1'b0, l);
    v = {h, l};
  endtask

  task automatic start(input logic [2:0] op, input logic [31:0] a, b, input logic r);
    mdop = op; rs_val = a; rt_val = b; req = r; mdstart = 1;
    tick();
    mdstart = 0; req = 0;
  endtask

  task automatic hl_wr(input logic sel, input logic [31:0] v, input logic r);
    hlwrite = 1; hlsel = sel; rs_val = v; req = r;
    tick();
    hlwrite = 0; hlsel = 0; req = 0;
  endtask

  task automatic busy_len(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    logic [63:0] hl;
    rst_n = 0;
    #12;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    hlsel = 1; hlread = 0; #1; v = hl_rdata;
    n_total++; if (v !== 32'h0) $display("FAIL rdata_noread: got %h want 0", v); else n_pass++;
    rst_n = 1;
    tick();
    rd_hl(hl);
    n_total++; if (hl !== 64'h0) $display("FAIL reset_hilo: got %h want 0", hl); else n_pass++;
  endtask

  task automatic test_mthlo();
    logic [31:0] v;
    hl_wr(1'b1, 32'h12345678, 1'b0); m_hi = 32'h12345678;
    rd(1'b1, v);
    n_total++; if (v !== 32'h12345678) $display("FAIL mthi: got %h want 12345678", v); else n_pass++;
    hl_wr(1'b0, 32'hDEADBEEF, 1'b1);
    rd(1'b0, v);
    n_total++; if (v !== m_lo) $display("FAIL mtlo_req: got %h want %h", v, m_lo); else n_pass++;
    hl_wr(1'b0, 32'hCAFEBABE, 1'b0); m_lo = 32'hCAFEBABE;
    rd(1'b0, v);
    n_total++; if (v !== 32'hCAFEBABE) $display("FAIL mtlo: got %h want cafebabe", v); else n_pass++;
  endtask

  task automatic test_mult();
    logic [31:0] v;
    logic [63:0] hl;
    int n;
    start(3'd0, 32'hFFFFFFFE, 32'd3, 1'b0);
    rd(1'b0, v);
    n_total++; if (v !== m_lo) $display("FAIL mult_old_lo: got %h want %h", v, m_lo); else n_pass++;
    busy_len(n);
    n_total++; if (n != 5) $display("FAIL mult_busy: got %0d want 5", n); else n_pass++;
    rd_hl(hl);
    {m_hi, m_lo} = 64'hFFFFFFFF_FFFFFFFA;
    n_total++; if (hl !== 64'hFFFFFFFF_FFFFFFFA) $display("FAIL mult_res: got %h want fffffffffffffffa", hl); else n_pass++;
  endtask

  task automatic test_div();
    logic [63:0] hl;
    int n;
    start(3'd3, 32'd7, 32'd0, 1'b0);
    busy_len(n);
    n_total++; if (n != 10) $display("FAIL divu0_busy: got %0d want 10", n); else n_pass++;
    rd_hl(hl);
    n_total++; if (hl !== {m_hi, m_lo}) $display("FAIL divu0_res: got %h want %h", hl, {m_hi, m_lo}); else n_pass++;
    start(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
    busy_len(n);
    rd_hl(hl);
    {m_hi, m_lo} = 64'hFFFFFFFF_FFFFFFFD;
    n_total++; if (hl !== 64'hFFFFFFFF_FFFFFFFD) $display("FAIL div_neg: got %h want fffffffffffffffd", hl); else n_pass++;
  endtask

  task automatic test_req();
    logic [63:0] hl;
    int n;
    start(3'd1, 32'd9, 32'd9, 1'b1);
    n_total++; if (busy !== 1'b0) $display("FAIL req_start_busy: got %b want 0", busy); else n_pass++;
    rd_hl(hl);
    n_total++; if (hl !== {m_hi, m_lo}) $display("FAIL req_start_hl: got %h want %h", hl, {m_hi, m_lo}); else n_pass++;
    start(3'd1, 32'h10000, 32'h30000, 1'b0);
    tick();
    req = 1; tick(); req = 0;
    busy_len(n);
    n_total++; if (n != 3) $display("FAIL req_mid_busy: got %0d want 3", n); else n_pass++;
    rd_hl(hl);
    {m_hi, m_lo} = 64'h3_00000000;
    n_total++; if (hl !== 64'h3_00000000) $display("FAIL req_mid_res: got %h want 300000000", hl); else n_pass++;
  endtask

  task automatic test_madd();
    logic [63:0] hl;
    int n;
    hl_wr(1'b1, 32'h0, 1'b0);
    hl_wr(1'b0, 32'hFFFFFFFF, 1'b0);
    {m_hi, m_lo} = 64'h0_FFFFFFFF;
    start(3'd5, 32'd1, 32'd1, 1'b0);
    busy_len(n);
    rd_hl(hl);
`ifdef MDU_MADD_EN
    n_total++; if (n != 5) $display("FAIL maddu_busy: got %0d want 5", n); else n_pass++;
    {m_hi, m_lo} = 64'h1_00000000;
`else
    n_total++; if (n != 0) $display("FAIL maddu_off_busy: got %0d want 0", n); else n_pass++;
`endif
    n_total++; if (hl !== {m_hi, m_lo}) $display("FAIL maddu_res: got %h want %h", hl, {m_hi, m_lo}); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [2:0] op;
    logic [31:0] a, b;
    logic [63:0] pend, hl;
    logic r;
    int n, want;
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      r = ($urandom_range(0, 5) == 0);
      pend = ref_md(op, a, b, {m_hi, m_lo});
      start(op, a, b, r);
      busy_len(n);
      want = (op_active(op) && !r) ? op_lat(op) : 0;
      n_total++; if (n != want) $display("FAIL rnd_busy[%0d] op%0d: got %0d want %0d", i, op, n, want); else n_pass++;
      if (want != 0) {m_hi, m_lo} = pend;
      rd_hl(hl);
      n_total++; if (hl !== {m_hi, m_lo}) $display("FAIL rnd_res[%0d] op%0d a=%h b=%h: got %h want %h", i, op, a, b, hl, {m_hi, m_lo}); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] hl;
    int n;
    start(3'd2, 32'd100, 32'd7, 1'b0);
    tick(); tick(); tick();
    rst_n = 0;
    #1;
    n_total++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", busy); else n_pass++;
    rd_hl(hl);
    {m_hi, m_lo} = 64'h0;
    n_total++; if (hl !== 64'h0) $display("FAIL rst_mid_hl: got %h want 0", hl); else n_pass++;
    tick();
    rst_n = 1;
    tick();
    start(3'd0, 32'd6, 32'd7, 1'b0);
    busy_len(n);
    rd_hl(hl);
    n_total++; if (n != 5 || hl !== 64'd42) $display("FAIL post_rst_mult: got busy %0d hl %h want 5 / 2a", n, hl); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_mthlo();
    test_mult();
    test_div();
    test_req();
    test_madd();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
